// File: rtl/column_buffer_mc.sv
`default_nettype none
// ============================================================================
// column_buffer_mc : NUM_COL independent circular column FIFOs with drop
//                    protection, sticky error flags and mark/rewind reuse.
// Revision: 1.0
// ============================================================================
module column_buffer_mc #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_COL    = 4,
  localparam int COL_W     = $clog2(NUM_COL)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_req,
  input  logic [COL_W-1:0]      wr_col,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_req,
  input  logic [COL_W-1:0]      rd_col,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic [COL_W-1:0]      rd_col_out,
  input  logic [NUM_COL-1:0]    keep,
  input  logic                  mark_req,
  input  logic                  rewind_req,
  input  logic [COL_W-1:0]      ctl_col,
  output logic [NUM_COL-1:0]    full,
  output logic [NUM_COL-1:0]    empty,
  output logic                  ovf,
  output logic                  udf
);

  localparam int            DEPTH   = 2 ** ADDR_WIDTH;
  localparam int            PW      = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  logic [PW-1:0]         wp_q [NUM_COL];
  logic [PW-1:0]         wp_d [NUM_COL];
  logic [PW-1:0]         rp_q [NUM_COL];
  logic [PW-1:0]         rp_d [NUM_COL];
  logic [PW-1:0]         mp_q [NUM_COL];
  logic [PW-1:0]         mp_d [NUM_COL];
  logic [DATA_WIDTH-1:0] bank [NUM_COL][DEPTH];

  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [COL_W-1:0]      rd_col_out_q, rd_col_out_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  wr_acc;
  logic                  rd_acc;

  // Entries from the mark up to the write pointer are protected, so fullness
  // is measured from mp while emptiness is measured from rp.
  for (genvar c = 0; c < NUM_COL; c++) begin : g_flags
    logic [PW-1:0] avail;
    logic [PW-1:0] held;
    assign avail    = wp_q[c] - rp_q[c];
    assign held     = wp_q[c] - mp_q[c];
    assign empty[c] = (avail == '0);
    assign full[c]  = (held == DEPTH_P);
  end

  assign wr_acc = wr_req && !full[wr_col];
  assign rd_acc = rd_req && !empty[rd_col];

  always_comb begin
    ovf_d        = ovf_q | (wr_req && !wr_acc);
    udf_d        = udf_q | (rd_req && !rd_acc);
    rd_valid_d   = rd_acc;
    rd_data_d    = rd_data_q;
    rd_col_out_d = rd_col_out_q;
    if (rd_acc) begin
      rd_data_d    = bank[rd_col][rp_q[rd_col][ADDR_WIDTH-1:0]];
      rd_col_out_d = rd_col;
    end
    for (int c = 0; c < NUM_COL; c++) begin
      wp_d[c] = wp_q[c] + ((wr_acc && wr_col == COL_W'(c)) ? PW'(1) : PW'(0));
      rp_d[c] = rp_q[c] + ((rd_acc && rd_col == COL_W'(c)) ? PW'(1) : PW'(0));
      mp_d[c] = mp_q[c];
      if (keep[c]) begin
        // Rewind takes priority over a same-cycle mark.
        if (rewind_req && ctl_col == COL_W'(c)) begin
          rp_d[c] = mp_q[c];
        end else if (mark_req && ctl_col == COL_W'(c)) begin
          mp_d[c] = rp_d[c];
        end
      end else begin
        mp_d[c] = rp_d[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_COL; c++) begin
        wp_q[c] <= '0;
        rp_q[c] <= '0;
        mp_q[c] <= '0;
      end
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      rd_col_out_q <= '0;
      ovf_q        <= 1'b0;
      udf_q        <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_COL; c++) begin
        wp_q[c] <= wp_d[c];
        rp_q[c] <= rp_d[c];
        mp_q[c] <= mp_d[c];
      end
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      rd_col_out_q <= rd_col_out_d;
      ovf_q        <= ovf_d;
      udf_q        <= udf_d;
    end
  end

  // Storage is not reset.
  always_ff @(posedge clk) begin
    if (wr_acc && !reset) begin
      bank[wr_col][wp_q[wr_col][ADDR_WIDTH-1:0]] <= wr_data;
    end
  end

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign rd_col_out = rd_col_out_q;
  assign ovf        = ovf_q;
  assign udf        = udf_q;

endmodule
`default_nettype wire

// File: tb/tb_column_buffer_mc.sv
`default_nettype none
// ============================================================================
// tb_column_buffer_mc : directed + randomized bench for column_buffer_mc,
//                       checked against a queue-based reference model.
// Revision: 1.0
// ============================================================================
module tb_column_buffer_mc;

  localparam int DW    = 8;
  localparam int AW    = 6;
  localparam int NC    = 4;
  localparam int CW    = 2;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_req;
  logic [CW-1:0] wr_col;
  logic [DW-1:0] wr_data;
  logic          rd_req;
  logic [CW-1:0] rd_col;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [CW-1:0] rd_col_out;
  logic [NC-1:0] keep;
  logic          mark_req;
  logic          rewind_req;
  logic [CW-1:0] ctl_col;
  logic [NC-1:0] full;
  logic [NC-1:0] empty;
  logic          ovf;
  logic          udf;

  column_buffer_mc #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_COL(NC)) dut (
    .clk(clk), .reset(reset),
    .wr_req(wr_req), .wr_col(wr_col), .wr_data(wr_data),
    .rd_req(rd_req), .rd_col(rd_col), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_col_out(rd_col_out),
    .keep(keep), .mark_req(mark_req), .rewind_req(rewind_req), .ctl_col(ctl_col),
    .full(full), .empty(empty), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Model: per column, the queue holds every entry from the mark to the
  // write pointer; ro is how many of those have been read since the mark.
  logic [DW-1:0] hq [NC][$];
  int            ro [NC];
  logic          m_ovf, m_udf;
  logic          exp_valid;
  logic [DW-1:0] exp_data;
  logic [CW-1:0] exp_col;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_mis++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic commit(input int c);
    repeat (ro[c]) void'(hq[c].pop_front());
    ro[c] = 0;
  endtask

  task automatic cycle();
    bit            wa, ra, was_reset;
    logic [NC-1:0] ef, ee;
    @(posedge clk);
    was_reset = reset;
    if (reset) begin
      for (int c = 0; c < NC; c++) begin
        hq[c].delete();
        ro[c] = 0;
      end
      m_ovf = 0; m_udf = 0;
      exp_valid = 0; exp_data = '0; exp_col = '0;
    end else begin
      wa = wr_req && (hq[wr_col].size() != DEPTH);
      ra = rd_req && (ro[rd_col] != hq[rd_col].size());
      if (wr_req && !wa) m_ovf = 1;
      if (rd_req && !ra) m_udf = 1;
      exp_valid = ra;
      if (ra) begin
        exp_data = hq[rd_col][ro[rd_col]];
        exp_col  = rd_col;
      end
      if (wa) hq[wr_col].push_back(wr_data);
      if (ra) ro[rd_col]++;
      for (int c = 0; c < NC; c++) begin
        if (!keep[c]) commit(c);
        else if (rewind_req && ctl_col == CW'(c)) ro[c] = 0;
        else if (mark_req && ctl_col == CW'(c)) commit(c);
      end
    end
    for (int c = 0; c < NC; c++) begin
      ef[c] = (hq[c].size() == DEPTH);
      ee[c] = (ro[c] == hq[c].size());
    end
    #1;
    check("rd_valid", rd_valid, exp_valid);
    if (exp_valid || was_reset) begin
      check("rd_data", rd_data, exp_data);
      check("rd_col_out", rd_col_out, exp_col);
    end
    check("full", full, ef);
    check("empty", empty, ee);
    check("ovf", ovf, m_ovf);
    check("udf", udf, m_udf);
  endtask

  task automatic idle();
    wr_req = 0; rd_req = 0; mark_req = 0; rewind_req = 0; reset = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    cycle();
    reset = 0;
  endtask

  task automatic wr(input logic [CW-1:0] c, input logic [DW-1:0] d);
    idle(); wr_req = 1; wr_col = c; wr_data = d;
    cycle();
    idle();
  endtask

  task automatic rd(input logic [CW-1:0] c);
    idle(); rd_req = 1; rd_col = c;
    cycle();
    idle();
  endtask

  task automatic ctl(input bit is_rewind, input logic [CW-1:0] c);
    idle(); ctl_col = c;
    if (is_rewind) rewind_req = 1; else mark_req = 1;
    cycle();
    idle();
  endtask

  int wr_pct;

  initial begin
    idle();
    wr_col = '0; wr_data = '0; rd_col = '0; ctl_col = '0; keep = '0;
    do_reset();
    do_reset();
    check("reset_empty", empty, 4'hF);
    check("reset_full", full, 4'h0);

    // Simple FIFO on column 2.
    for (int i = 0; i < 4; i++) wr(2'd2, 8'h10 + 8'(i));
    for (int i = 0; i < 4; i++) begin
      rd(2'd2);
      check("t1_data", rd_data, 8'h10 + 8'(i));
      check("t1_col", rd_col_out, 2);
    end
    cycle();
    check("t1_valid_off", rd_valid, 0);
    check("t1_empty", empty, 4'hF);

    // Fill column 0, overflow, drain, then wrap.
    for (int i = 0; i < DEPTH; i++) wr(2'd0, 8'(i));
    check("t2_full", full[0], 1);
    wr(2'd0, 8'hEE);
    check("t2_ovf", ovf, 1);
    for (int i = 0; i < DEPTH; i++) begin
      rd(2'd0);
      check("t2_data", rd_data, 8'(i));
    end
    check("t2_empty", empty[0], 1);
    wr(2'd0, 8'h55);
    for (int i = 0; i < 100; i++) begin
      idle(); wr_req = 1; wr_col = 0; wr_data = 8'($urandom); rd_req = 1; rd_col = 0;
      cycle();
    end
    idle();

    // Mark / rewind reuse on column 1.
    do_reset();
    keep = 4'b0010;
    for (int i = 0; i < 4; i++) wr(2'd1, 8'hA0 + 8'(i));
    ctl(0, 2'd1);
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 4; i++) begin
        rd(2'd1);
        check("t3_data", rd_data, 8'hA0 + 8'(i));
      end
      if (pass == 0) ctl(1, 2'd1);
    end
    check("t3_empty", empty[1], 1);
    keep = 4'b0000;
    cycle();

    // Held entries block writes until a mark frees them (column 3).
    do_reset();
    keep = 4'b1000;
    for (int i = 0; i < DEPTH; i++) wr(2'd3, 8'(i * 3));
    for (int i = 0; i < DEPTH; i++) rd(2'd3);
    check("t4_full_held", full[3], 1);
    check("t4_empty", empty[3], 1);
    wr(2'd3, 8'h77);
    check("t4_ovf", ovf, 1);
    ctl(0, 2'd3);
    check("t4_full_freed", full[3], 0);
    wr(2'd3, 8'h78);
    check("t4_accepted", empty[3], 0);
    rd(2'd3);
    check("t4_data", rd_data, 8'h78);
    keep = 4'b0000;

    // Simultaneous read and write on an empty column.
    do_reset();
    idle(); wr_req = 1; wr_col = 0; wr_data = 8'h3C; rd_req = 1; rd_col = 0;
    cycle();
    idle();
    check("t5_udf", udf, 1);
    check("t5_valid", rd_valid, 0);
    rd(2'd0);
    check("t5_data", rd_data, 8'h3C);

    // Reset during an accepted read.
    do_reset();
    for (int c = 0; c < NC; c++)
      for (int i = 0; i < 5; i++) wr(CW'(c), 8'(c * 16 + i));
    idle(); rd_req = 1; rd_col = 0; reset = 1;
    cycle();
    idle();
    check("t6_valid", rd_valid, 0);
    check("t6_empty", empty, 4'hF);
    check("t6_ovf", ovf, 0);
    check("t6_udf", udf, 0);
    wr(2'd1, 8'h5A);
    rd(2'd1);
    check("t6_data", rd_data, 8'h5A);

    // Randomized traffic.
    wr_pct = 50;
    for (int n = 0; n < 3000; n++) begin
      if (n % 500 == 0) wr_pct = (n / 500 % 3 == 0) ? 80 : ((n / 500 % 3 == 1) ? 50 : 25);
      idle();
      wr_req  = ($urandom_range(0, 99) < wr_pct);
      wr_col  = CW'($urandom);
      wr_data = DW'($urandom);
      rd_req  = ($urandom_range(0, 99) < 100 - wr_pct);
      rd_col  = CW'($urandom);
      if ($urandom_range(0, 99) < 2) keep = NC'($urandom);
      ctl_col  = CW'($urandom);
      mark_req = ($urandom_range(0, 99) < 6);
      rewind_req = keep[ctl_col] && ($urandom_range(0, 99) < 5);
      reset    = ($urandom_range(0, 999) < 3);
      cycle();
    end
    idle();
    keep = '0;
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
